// File: rtl/axi_master_mc.sv
// Multi-channel AXI3 master: NUM_CH requesters share one port through independent
// round-robin read and write engines; reads wait while a write to their line is in flight.
module axi_master_mc #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              rd_req,
    input  logic [NUM_CH*ADDR_W-1:0]       rd_addr,
    input  logic [NUM_CH-1:0]              rd_single,
    output logic [NUM_CH-1:0]              rd_done,
    output logic [LINE_WORDS*32-1:0]       rd_line,
    output logic                           rd_err,
    input  logic [NUM_CH-1:0]              wr_req,
    input  logic [NUM_CH*ADDR_W-1:0]       wr_addr,
    input  logic [NUM_CH-1:0]              wr_single,
    input  logic [NUM_CH*4-1:0]            wr_strb,
    input  logic [NUM_CH*LINE_WORDS*32-1:0] wr_line,
    output logic [NUM_CH-1:0]              wr_done,
    output logic                           wr_err,
    output logic                           stallreq,
    output logic [3:0]                     arid,
    output logic [ADDR_W-1:0]              araddr,
    output logic [3:0]                     arlen,
    output logic [2:0]                     arsize,
    output logic [1:0]                     arburst,
    output logic [1:0]                     arlock,
    output logic [3:0]                     arcache,
    output logic [2:0]                     arprot,
    output logic                           arvalid,
    input  logic                           arready,
    input  logic [3:0]                     rid,
    input  logic [31:0]                    rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rlast,
    input  logic                           rvalid,
    output logic                           rready,
    output logic [3:0]                     awid,
    output logic [ADDR_W-1:0]              awaddr,
    output logic [3:0]                     awlen,
    output logic [2:0]                     awsize,
    output logic [1:0]                     awburst,
    output logic [1:0]                     awlock,
    output logic [3:0]                     awcache,
    output logic [2:0]                     awprot,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [3:0]                     wid,
    output logic [31:0]                    wdata,
    output logic [3:0]                     wstrb,
    output logic                           wlast,
    output logic                           wvalid,
    input  logic                           wready,
    input  logic [3:0]                     bid,
    input  logic [1:0]                     bresp,
    input  logic                           bvalid,
    output logic                           bready
);

    localparam int unsigned CH_W      = $clog2(NUM_CH);
    localparam int unsigned BEAT_W    = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS * 4);
    localparam int unsigned LINE_W    = ADDR_W - OFF_W;
    localparam int unsigned LINE_BITS = LINE_WORDS * 32;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_t;
    typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} wr_state_t;

    rd_state_t             r_state;
    wr_state_t             w_state;
    logic [CH_W-1:0]       r_ptr, r_ch, w_ptr, w_ch;
    logic [NUM_CH-1:0]     r_mask, w_mask;
    logic [BEAT_W-1:0]     r_beat, w_beat, w_nbeat;
    logic [LINE_W-1:0]     w_line;
    logic                  w_single;
    logic [3:0]            w_strb;
    logic [LINE_BITS-1:0]  w_buf;

    logic [NUM_CH-1:0]     r_elig, w_elig;
    logic                  r_gnt_vld, w_gnt_vld;
    logic [CH_W-1:0]       r_gnt_ch, w_gnt_ch;
    logic [ADDR_W-1:0]     r_gnt_addr, w_gnt_addr;
    logic [LINE_W-1:0]     w_gnt_line;
    logic                  r_gnt_single, w_gnt_single;
    logic [3:0]            w_gnt_strb;

    logic unused_ok;
    assign unused_ok = ^{rid, bid, rresp[0], bresp[0]};

    // Channel index at offset i from the round-robin pointer, wrapping at NUM_CH.
    function automatic logic [CH_W-1:0] rot(input logic [CH_W-1:0] p, input int unsigned i);
        int unsigned s;
        s = 32'(p) + i;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
    endfunction

    function automatic logic [2:0] size_of(input logic [3:0] s);
        case (s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
            4'b0011, 4'b1100:                   return 3'd1;
            default:                            return 3'd2;
        endcase
    endfunction

    assign w_nbeat = w_beat + BEAT_W'(1);

    // Write arbitration: first requesting, unmasked channel at or after w_ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_elig    = wr_req & ~w_mask;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (w_elig[rot(w_ptr, 32'(i))]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = rot(w_ptr, 32'(i));
            end
        end
    end

    assign w_gnt_addr   = wr_addr[int'(w_gnt_ch) * int'(ADDR_W) +: ADDR_W];
    assign w_gnt_line   = w_gnt_addr[ADDR_W-1:OFF_W];
    assign w_gnt_single = wr_single[w_gnt_ch];
    assign w_gnt_strb   = wr_strb[int'(w_gnt_ch) * 4 +: 4];

    // A read hazards against the in-flight write line, or the write granted this same cycle.
    always_comb begin
        r_elig    = '0;
        r_gnt_vld = 1'b0;
        r_gnt_ch  = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            r_elig[c] = rd_req[c] & ~r_mask[c]
                & ~((w_state != W_IDLE) && (rd_addr[c * int'(ADDR_W) + int'(OFF_W) +: LINE_W] == w_line))
                & ~((w_state == W_IDLE) && w_gnt_vld
                    && (rd_addr[c * int'(ADDR_W) + int'(OFF_W) +: LINE_W] == w_gnt_line));
        end
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (r_elig[rot(r_ptr, 32'(i))]) begin
                r_gnt_vld = 1'b1;
                r_gnt_ch  = rot(r_ptr, 32'(i));
            end
        end
    end

    assign r_gnt_addr   = rd_addr[int'(r_gnt_ch) * int'(ADDR_W) +: ADDR_W];
    assign r_gnt_single = rd_single[r_gnt_ch];

    assign stallreq = (r_state != R_IDLE) | (w_state != W_IDLE);

    // Read engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_ptr   <= '0;
            r_ch    <= '0;
            r_mask  <= '0;
            r_beat  <= '0;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= 3'b010;
            arburst <= 2'b01;
            arlock  <= '0;
            arcache <= '0;
            arprot  <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            rd_done <= '0;
            rd_line <= '0;
            rd_err  <= 1'b0;
        end else begin
            r_mask  <= '0;
            rd_done <= '0;
            case (r_state)
                R_IDLE: begin
                    if (r_gnt_vld) begin
                        r_ch    <= r_gnt_ch;
                        arid    <= 4'(r_gnt_ch);
                        araddr  <= r_gnt_single ? r_gnt_addr
                                                : {r_gnt_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        arlen   <= r_gnt_single ? 4'd0 : 4'(LINE_WORDS - 1);
                        arsize  <= 3'b010;
                        arvalid <= 1'b1;
                        r_beat  <= '0;
                        rd_line <= '0;
                        rd_err  <= 1'b0;
                        r_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        rd_line[{r_beat, 5'd0} +: 32] <= rdata;
                        r_beat <= r_beat + BEAT_W'(1);
                        if (rresp[1]) rd_err <= 1'b1;
                        if (rlast) begin
                            rready        <= 1'b0;
                            rd_done[r_ch] <= 1'b1;
                            r_state       <= R_DONE;
                        end
                    end
                end
                R_DONE: begin
                    r_mask[r_ch] <= 1'b1;
                    r_ptr        <= next_ch(r_ch);
                    r_state      <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            w_ptr    <= '0;
            w_ch     <= '0;
            w_mask   <= '0;
            w_beat   <= '0;
            w_line   <= '0;
            w_single <= 1'b0;
            w_strb   <= '0;
            w_buf    <= '0;
            awid     <= '0;
            awaddr   <= '0;
            awlen    <= '0;
            awsize   <= 3'b010;
            awburst  <= 2'b01;
            awlock   <= '0;
            awcache  <= '0;
            awprot   <= '0;
            awvalid  <= 1'b0;
            wid      <= '0;
            wdata    <= '0;
            wstrb    <= '0;
            wlast    <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            wr_done  <= '0;
            wr_err   <= 1'b0;
        end else begin
            w_mask  <= '0;
            wr_done <= '0;
            case (w_state)
                W_IDLE: begin
                    if (w_gnt_vld) begin
                        w_ch     <= w_gnt_ch;
                        w_line   <= w_gnt_line;
                        w_single <= w_gnt_single;
                        w_strb   <= w_gnt_strb;
                        w_buf    <= wr_line[int'(w_gnt_ch) * int'(LINE_BITS) +: LINE_BITS];
                        awid     <= 4'(w_gnt_ch);
                        wid      <= 4'(w_gnt_ch);
                        awaddr   <= w_gnt_single ? w_gnt_addr
                                                 : {w_gnt_line, OFF_W'(0)};
                        awlen    <= w_gnt_single ? 4'd0 : 4'(LINE_WORDS - 1);
                        awsize   <= w_gnt_single ? size_of(w_gnt_strb) : 3'b010;
                        awvalid  <= 1'b1;
                        w_state  <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= w_buf[31:0];
                        wstrb   <= w_single ? w_strb : 4'hF;
                        wlast   <= w_single;
                        w_beat  <= '0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid  <= 1'b0;
                            wlast   <= 1'b0;
                            wdata   <= '0;
                            wstrb   <= '0;
                            bready  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_nbeat;
                            wdata  <= w_buf[{w_nbeat, 5'd0} +: 32];
                            wlast  <= (w_nbeat == BEAT_W'(LINE_WORDS - 1));
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready        <= 1'b0;
                        wr_done[w_ch] <= 1'b1;
                        wr_err        <= bresp[1];
                        w_state       <= W_DONE;
                    end
                end
                W_DONE: begin
                    wr_err       <= 1'b0;
                    w_mask[w_ch] <= 1'b1;
                    w_ptr        <= next_ch(w_ch);
                    w_state      <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_mc.sv
// Directed bench for axi_master_mc: bench-side AXI slave, hand-computed expectations per scenario.
module tb_axi_master_mc;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    rd_req, rd_single, rd_done, wr_req, wr_single, wr_done;
    logic [95:0]   rd_addr, wr_addr;
    logic [511:0]  rd_line;
    logic          rd_err, wr_err, stallreq;
    logic [11:0]   wr_strb;
    logic [1535:0] wr_line;
    logic [3:0]    arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0]   araddr, awaddr, rdata, wdata;
    logic [2:0]    arsize, arprot, awsize, awprot;
    logic [1:0]    arburst, arlock, rresp, awburst, awlock, bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_master_mc #(.NUM_CH(3), .LINE_WORDS(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_single(rd_single), .rd_done(rd_done),
        .rd_line(rd_line), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_single(wr_single), .wr_strb(wr_strb),
        .wr_line(wr_line), .wr_done(wr_done), .wr_err(wr_err), .stallreq(stallreq),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Read requester plus AR/R slave; returns what the DUT presented.
    task automatic run_read(input int ch, input logic [31:0] addr, input logic single,
                            input int ar_wait, input int nbeats, input int err_beat,
                            input logic [31:0] dbase,
                            output logic [31:0] o_araddr, output logic [3:0] o_arlen,
                            output logic [3:0] o_arid, output logic [2:0] o_arsize,
                            output int o_lat, output logic [2:0] o_done,
                            output logic [511:0] o_line, output logic o_err, output logic o_to);
        o_araddr = '0; o_arlen = '0; o_arid = '0; o_arsize = '0;
        o_done = '0; o_line = '0; o_err = 1'b0; o_to = 1'b0; o_lat = 0;
        @(negedge clk);
        rd_req[ch] = 1'b1;
        rd_addr[ch*32 +: 32] = addr;
        rd_single[ch] = single;
        do begin
            @(negedge clk);
            o_lat++;
        end while (!arvalid && o_lat < 200);
        if (!arvalid) begin
            o_to = 1'b1;
            rd_req[ch] = 1'b0;
            return;
        end
        o_araddr = araddr; o_arlen = arlen; o_arid = arid; o_arsize = arsize;
        repeat (ar_wait) @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            rvalid = 1'b1;
            rdata  = dbase + 32'(i);
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = (i == nbeats - 1);
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        o_done = rd_done; o_line = rd_line; o_err = rd_err;
        rd_req[ch] = 1'b0;
    endtask

    // Write requester plus AW/W/B slave; records every accepted W beat.
    task automatic run_write(input int ch, input logic [31:0] addr, input logic single,
                             input logic [3:0] strb, input logic [511:0] data,
                             input logic toggle, input logic [1:0] resp,
                             output logic [31:0] o_awaddr, output logic [3:0] o_awlen,
                             output logic [2:0] o_awsize, output logic [3:0] o_awid,
                             output logic [511:0] o_data, output logic [15:0] o_wlast,
                             output int o_nbeats, output logic [3:0] o_strb0,
                             output logic o_bready, output logic [2:0] o_done,
                             output logic o_err, output logic o_to);
        int k;
        int cyc;
        logic last;
        o_awaddr = '0; o_awlen = '0; o_awsize = '0; o_awid = '0; o_data = '0; o_wlast = '0;
        o_nbeats = 0; o_strb0 = '0; o_bready = 1'b0; o_done = '0; o_err = 1'b0; o_to = 1'b0;
        @(negedge clk);
        wr_req[ch] = 1'b1;
        wr_addr[ch*32 +: 32] = addr;
        wr_single[ch] = single;
        wr_strb[ch*4 +: 4] = strb;
        wr_line[ch*512 +: 512] = data;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!awvalid && k < 200);
        if (!awvalid) begin
            o_to = 1'b1;
            wr_req[ch] = 1'b0;
            return;
        end
        o_awaddr = awaddr; o_awlen = awlen; o_awsize = awsize; o_awid = awid;
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        cyc = 0;
        last = 1'b0;
        while (!last && cyc < 200) begin
            wready = toggle ? cyc[0] : 1'b1;
            if (wvalid && wready) begin
                if (o_nbeats < 16) begin
                    o_data[o_nbeats*32 +: 32] = wdata;
                    o_wlast[o_nbeats] = wlast;
                end
                if (o_nbeats == 0) o_strb0 = wstrb;
                o_nbeats++;
                last = wlast;
            end
            @(negedge clk);
            cyc++;
        end
        wready = 1'b0;
        if (!last) begin
            o_to = 1'b1;
            wr_req[ch] = 1'b0;
            return;
        end
        o_bready = bready;
        bvalid = 1'b1;
        bresp  = resp;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        o_done = wr_done; o_err = wr_err;
        wr_req[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({arvalid, awvalid, wvalid, rready, bready, rd_done, wr_done, rd_err, wr_err} !== 13'b0)
            begin bad++; $display("FAIL reset_ctrl got=%b want=0",
                {arvalid, awvalid, wvalid, rready, bready, rd_done, wr_done, rd_err, wr_err}); end
        total++;
        if ({arsize, arburst, awsize, awburst} !== 10'b010_01_010_01)
            begin bad++; $display("FAIL reset_size_burst got=%b want=0100101001",
                {arsize, arburst, awsize, awburst}); end
        total++;
        if ({araddr, arlen, arid, awaddr, awlen, awid, wdata, wstrb} !== 120'b0)
            begin bad++; $display("FAIL reset_addr_len got=%h want=0",
                {araddr, arlen, arid, awaddr, awlen, awid, wdata, wstrb}); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (stallreq !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stallreq); end
    endtask

    task automatic test_line_read();
        logic [31:0] a; logic [3:0] len, id; logic [2:0] sz, dn; int lat;
        logic [511:0] ln, exp_line; logic er, to;
        for (int i = 0; i < 16; i++) exp_line[i*32 +: 32] = 32'(i);
        run_read(1, 32'h1000_0040, 1'b0, 2, 16, -1, 32'h0, a, len, id, sz, lat, dn, ln, er, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL line_timeout got=%b want=0", to); end
        total++;
        if (lat != 1) begin bad++; $display("FAIL line_latency got=%0d want=1", lat); end
        total++;
        if ({a, len, id, sz} !== {32'h1000_0040, 4'd15, 4'd1, 3'd2})
            begin bad++; $display("FAIL line_ar got=%h/%0d/%0d/%0d want=10000040/15/1/2", a, len, id, sz); end
        total++;
        if (dn !== 3'b010) begin bad++; $display("FAIL line_done got=%b want=010", dn); end
        total++;
        if (ln !== exp_line) begin bad++; $display("FAIL line_data got=%h want=%h", ln, exp_line); end
        total++;
        if (er !== 1'b0) begin bad++; $display("FAIL line_err got=%b want=0", er); end
        @(negedge clk);
        total++;
        if (rd_done !== 3'b000) begin bad++; $display("FAIL line_done_pulse got=%b want=000", rd_done); end
    endtask

    task automatic test_single_read();
        logic [31:0] a; logic [3:0] len, id; logic [2:0] sz, dn; int lat;
        logic [511:0] ln; logic er, to;
        run_read(2, 32'hBFAF_8004, 1'b1, 0, 1, -1, 32'h1234_5678, a, len, id, sz, lat, dn, ln, er, to);
        total++;
        if ({to, a, len, id} !== {1'b0, 32'hBFAF_8004, 4'd0, 4'd2})
            begin bad++; $display("FAIL single_ar got=%b/%h/%0d/%0d want=0/bfaf8004/0/2", to, a, len, id); end
        total++;
        if (ln[31:0] !== 32'h1234_5678) begin bad++; $display("FAIL single_word0 got=%h want=12345678", ln[31:0]); end
        total++;
        if (ln[511:32] !== 480'b0) begin bad++; $display("FAIL single_upper got=%h want=0", ln[511:32]); end
        total++;
        if (dn !== 3'b100) begin bad++; $display("FAIL single_done got=%b want=100", dn); end
    endtask

    task automatic test_round_robin();
        logic [3:0] ids [4];
        logic [2:0] dns [4];
        logic to;
        int k;
        to = 1'b0;
        @(negedge clk);
        rd_addr[31:0] = 32'h0000_5000; rd_addr[63:32] = 32'h0000_6004;
        rd_single[1:0] = 2'b11;
        rd_req[1:0] = 2'b11;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!arvalid && k < 50);
            if (!arvalid) to = 1'b1;
            ids[g] = arid;
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            rvalid = 1'b1; rlast = 1'b1; rdata = 32'(g);
            @(negedge clk);
            rvalid = 1'b0; rlast = 1'b0;
            dns[g] = rd_done;
            if (g == 3) rd_req[1:0] = 2'b00;
        end
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL rr_timeout got=%b want=0", to); end
        total++;
        if ({ids[0], ids[1], ids[2], ids[3]} !== 16'h0101)
            begin bad++; $display("FAIL rr_order got=%h%h%h%h want=0101", ids[0], ids[1], ids[2], ids[3]); end
        total++;
        if ({dns[0], dns[1], dns[2], dns[3]} !== {3'b001, 3'b010, 3'b001, 3'b010})
            begin bad++; $display("FAIL rr_done got=%b %b %b %b want=001 010 001 010",
                dns[0], dns[1], dns[2], dns[3]); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_hazard();
        logic [511:0] wl, wd, rl_exp, rl;
        logic [31:0] wa, ra; logic [3:0] wlen, wido, rlen, rido; logic [2:0] wsz, rsz, wdn, rdn;
        logic [15:0] wlm; int nb, rlat; logic [3:0] st0; logic wbr, wer, wto, rer, rto;
        logic seen, early, got_ar;
        for (int i = 0; i < 16; i++) begin
            wl[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            rl_exp[i*32 +: 32] = 32'h55 + 32'(i);
        end
        seen = 1'b0; early = 1'b0; got_ar = 1'b0;
        fork
            run_write(1, 32'h0000_2000, 1'b0, 4'hF, wl, 1'b1, 2'b00,
                      wa, wlen, wsz, wido, wd, wlm, nb, st0, wbr, wdn, wer, wto);
            run_read(1, 32'h0000_2010, 1'b0, 0, 16, -1, 32'h55,
                     ra, rlen, rido, rsz, rlat, rdn, rl, rer, rto);
            begin
                for (int k = 0; k < 300 && !got_ar; k++) begin
                    @(negedge clk);
                    if (arvalid) begin
                        got_ar = 1'b1;
                        if (!seen) early = 1'b1;
                    end
                    if (wr_done !== 3'b000) seen = 1'b1;
                end
            end
        join
        total++;
        if ({wto, wa, wlen, wsz, wido} !== {1'b0, 32'h0000_2000, 4'd15, 3'd2, 4'd1})
            begin bad++; $display("FAIL wline_aw got=%b/%h/%0d/%0d/%0d want=0/00002000/15/2/1",
                wto, wa, wlen, wsz, wido); end
        total++;
        if (nb != 16 || wd !== wl) begin bad++; $display("FAIL wline_data beats=%0d got=%h want=16 %h", nb, wd, wl); end
        total++;
        if ({wlm, st0} !== {16'h8000, 4'hF}) begin bad++; $display("FAIL wline_wlast got=%h/%h want=8000/f", wlm, st0); end
        total++;
        if ({wbr, wdn, wer} !== {1'b1, 3'b010, 1'b0})
            begin bad++; $display("FAIL wline_resp got=%b/%b/%b want=1/010/0", wbr, wdn, wer); end
        total++;
        if ({got_ar, early} !== 2'b10)
            begin bad++; $display("FAIL hazard_hold seen_ar=%b early=%b want=1 0", got_ar, early); end
        total++;
        if ({rto, ra, rdn} !== {1'b0, 32'h0000_2000, 3'b010} || rl !== rl_exp)
            begin bad++; $display("FAIL hazard_read got=%b/%h/%b want=0/00002000/010", rto, ra, rdn); end
    endtask

    task automatic test_single_write();
        logic [511:0] wd; logic [31:0] wa; logic [3:0] wlen, wido, st0; logic [2:0] wsz, wdn;
        logic [15:0] wlm; int nb; logic wbr, wer, wto;
        run_write(2, 32'h0000_3002, 1'b1, 4'b0100, {480'b0, 32'h00AA_0000}, 1'b0, 2'b00,
                  wa, wlen, wsz, wido, wd, wlm, nb, st0, wbr, wdn, wer, wto);
        total++;
        if ({wto, wa, wlen, wsz} !== {1'b0, 32'h0000_3002, 4'd0, 3'd0})
            begin bad++; $display("FAIL wsingle_aw got=%b/%h/%0d/%0d want=0/00003002/0/0", wto, wa, wlen, wsz); end
        total++;
        if ({st0, wlm, wd[31:0]} !== {4'b0100, 16'h0001, 32'h00AA_0000} || nb != 1)
            begin bad++; $display("FAIL wsingle_w got=%b/%h/%h/%0d want=0100/0001/00aa0000/1",
                st0, wlm, wd[31:0], nb); end
        total++;
        if ({wdn, wer} !== {3'b100, 1'b0}) begin bad++; $display("FAIL wsingle_done got=%b/%b want=100/0", wdn, wer); end
        run_write(2, 32'h0000_3006, 1'b1, 4'b1100, {480'b0, 32'hBEEF_0000}, 1'b0, 2'b10,
                  wa, wlen, wsz, wido, wd, wlm, nb, st0, wbr, wdn, wer, wto);
        total++;
        if ({wto, wsz, st0} !== {1'b0, 3'd1, 4'b1100})
            begin bad++; $display("FAIL whalf_size got=%b/%0d/%b want=0/1/1100", wto, wsz, st0); end
        total++;
        if ({wdn, wer} !== {3'b100, 1'b1}) begin bad++; $display("FAIL whalf_err got=%b/%b want=100/1", wdn, wer); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] a; logic [3:0] len, id; logic [2:0] sz, dn; int lat, k;
        logic [511:0] ln, exp_line; logic er, to, stray;
        @(negedge clk);
        rd_req[0] = 1'b1; rd_single[0] = 1'b0; rd_addr[31:0] = 32'h4000_0100;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!arvalid && k < 50);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rvalid = 1'b1; rdata = 32'(i);
            @(negedge clk);
        end
        rvalid = 1'b1; rdata = 32'd5; rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rready, arvalid, rd_done, stallreq} !== 6'b0)
            begin bad++; $display("FAIL rstmid_state got=%b want=000000", {rready, arvalid, rd_done, stallreq}); end
        rst = 1'b0; rvalid = 1'b0; rd_req[0] = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rd_done !== 3'b000 || arvalid !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%b want=0", stray); end
        for (int i = 0; i < 16; i++) exp_line[i*32 +: 32] = 32'h100 + 32'(i);
        run_read(0, 32'h4000_0104, 1'b0, 1, 16, 3, 32'h100, a, len, id, sz, lat, dn, ln, er, to);
        total++;
        if ({to, a, len, id, dn} !== {1'b0, 32'h4000_0100, 4'd15, 4'd0, 3'b001})
            begin bad++; $display("FAIL rstmid_reread got=%b/%h/%0d/%0d/%b want=0/40000100/15/0/001",
                to, a, len, id, dn); end
        total++;
        if (ln !== exp_line) begin bad++; $display("FAIL rstmid_data got=%h want=%h", ln, exp_line); end
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL rresp_err got=%b want=1", er); end
    endtask

    initial begin
        rst = 1'b1;
        rd_req = '0; rd_addr = '0; rd_single = '0;
        wr_req = '0; wr_addr = '0; wr_single = '0; wr_strb = '0; wr_line = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        test_reset();
        test_line_read();
        test_single_read();
        test_round_robin();
        test_write_hazard();
        test_single_write();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
